// File: rtl/rdi_flit_pkg.sv
// Flit layout shared by the RDI read and write datapaths: payload in the top
// DATA_W bits, flag bits at the bottom of the flit.
package rdi_flit_pkg;

  localparam int FLIT_W        = 512;
  localparam int DATA_LSB      = FLIT_W - 256;

  localparam int DATA_FLAG_BIT = 0;
  localparam int CRD_FLAG_BIT  = 1;
  localparam int ALCT_FLAG_BIT = 2;

  localparam logic [FLIT_W-1:0] DATA_BIT_MASK = FLIT_W'(1) << DATA_FLAG_BIT;
  localparam logic [FLIT_W-1:0] CRD_BIT_MASK  = FLIT_W'(1) << CRD_FLAG_BIT;
  localparam logic [FLIT_W-1:0] ALCT_BIT_MASK = FLIT_W'(1) << ALCT_FLAG_BIT;

  typedef struct packed {
    logic alct;
    logic crd;
    logic data;
  } flit_flags_t;

  function automatic flit_flags_t decode_flags(input logic [FLIT_W-1:0] f);
    flit_flags_t fl;
    fl.data = |(f & DATA_BIT_MASK);
    fl.crd  = |(f & CRD_BIT_MASK);
    fl.alct = |(f & ALCT_BIT_MASK);
    return fl;
  endfunction

endpackage

// File: rtl/rdi_rx_datapath_if.sv
// Bundle of the RDI receive datapath signals. Statistic counters exist only
// when RDI_RX_STATS_EN is defined.
interface rdi_rx_datapath_if #(
  parameter int FLIT_W = 512,
  parameter int DATA_W = 256,
  parameter int CW     = 4
);
  logic              enable;
  logic              pl_valid;
  logic [FLIT_W-1:0] pl_data;
  logic [DATA_W-1:0] rx_data;
  logic              rx_data_valid;
  logic              rx_data_ready;
  logic              crd_ret_req;
  logic              crd_ret_ack;
  logic              tx_cmd_sent;
  logic [CW-1:0]     tx_crd_avail;
  logic              tx_can_send;
  logic              alct_grant;
  logic              err_overflow;
  logic              err_credit;
`ifdef RDI_RX_STATS_EN
  logic [15:0]       stat_data_cnt;
  logic [15:0]       stat_crd_cnt;
  logic [15:0]       stat_alct_cnt;
`endif

  modport master (
    output enable, pl_valid, pl_data, rx_data_ready, crd_ret_ack, tx_cmd_sent,
    input  rx_data, rx_data_valid, crd_ret_req, tx_crd_avail, tx_can_send,
           alct_grant, err_overflow, err_credit
`ifdef RDI_RX_STATS_EN
    , input stat_data_cnt, stat_crd_cnt, stat_alct_cnt
`endif
  );

  modport slave (
    input  enable, pl_valid, pl_data, rx_data_ready, crd_ret_ack, tx_cmd_sent,
    output rx_data, rx_data_valid, crd_ret_req, tx_crd_avail, tx_can_send,
           alct_grant, err_overflow, err_credit
`ifdef RDI_RX_STATS_EN
    , output stat_data_cnt, stat_crd_cnt, stat_alct_cnt
`endif
  );

endinterface

// File: rtl/rdi_rx_fifo.sv
// Synchronous circular-buffer FIFO; pointers carry one wrap bit so full and
// empty are distinguishable. Push on full and pop on empty are ignored.
module rdi_rx_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_wr;
  logic             w_rd;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_wr    = i_push & ~o_full;
  assign w_rd    = i_pop & ~o_empty;
  assign o_rdata = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/rdi_rx_datapath.sv
// RDI receive datapath: flit capture, flag decode, RX payload FIFO, transmit
// credit tracking and credit-return requests. Optional counters: RDI_RX_STATS_EN.
module rdi_rx_datapath
  import rdi_flit_pkg::*;
#(
  parameter int NBYTES      = 64,
  parameter int DATA_W      = 256,
  parameter int RX_DEPTH    = 8,
  parameter int TX_CRD_INIT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  rdi_rx_datapath_if.slave   bus
);
  localparam int FLIT_W_L = NBYTES * 8;
  localparam int CMAX     = (RX_DEPTH > TX_CRD_INIT) ? RX_DEPTH : TX_CRD_INIT;
  localparam int CW       = $clog2(CMAX + 1);
  localparam logic [CW-1:0] CRD_INIT = CW'(TX_CRD_INIT);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  logic [FLIT_W_L-1:0] r_flit_p0;
  logic                r_vld_p0;
  flit_flags_t         w_flags_p0;
  logic                w_data_hit;
  logic                w_crd_hit;
  logic                w_alct_hit;

  logic [DATA_W-1:0]   r_pdata_p1;
  logic                r_push_p1;
  logic                r_alct_p1;

  logic [DATA_W-1:0]   w_rdata;
  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_ack;

  logic [CW-1:0]       r_tx_crd;
  logic [CW-1:0]       r_pend;
  logic                r_err_overflow;
  logic                r_err_credit;

  // Stage 0: capture; decode happens only from the registered flit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_vld_p0 <= 1'b0;
    else        r_vld_p0 <= bus.pl_valid & bus.enable;
  end

  always_ff @(posedge clk) begin
    if (bus.pl_valid & bus.enable) r_flit_p0 <= bus.pl_data;
  end

  assign w_flags_p0 = decode_flags(r_flit_p0);
  assign w_data_hit = r_vld_p0 & w_flags_p0.data;
  assign w_crd_hit  = r_vld_p0 & w_flags_p0.crd;
  assign w_alct_hit = r_vld_p0 & w_flags_p0.alct;

  // Stage 1: decode; payload staged for the FIFO write on the following edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_push_p1 <= 1'b0;
      r_alct_p1 <= 1'b0;
    end else begin
      r_push_p1 <= w_data_hit;
      r_alct_p1 <= w_alct_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (w_data_hit) r_pdata_p1 <= r_flit_p0[FLIT_W_L-1 -: DATA_W];
  end

  rdi_rx_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_push_p1),
    .i_pop   (bus.rx_data_ready),
    .i_wdata (r_pdata_p1),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_pop = bus.rx_data_ready & ~w_empty;
  assign w_ack = bus.crd_ret_ack & (r_pend != '0);

  // Stage 2: FIFO write; a push arriving while full is lost and flagged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_overflow <= 1'b0;
    end else if (r_push_p1 && w_full) begin
      r_err_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_crd     <= CRD_INIT;
      r_err_credit <= 1'b0;
    end else if (w_crd_hit && !bus.tx_cmd_sent) begin
      if (r_tx_crd == CRD_INIT) r_err_credit <= 1'b1;
      else                      r_tx_crd     <= r_tx_crd + CW'(1);
    end else if (bus.tx_cmd_sent && !w_crd_hit) begin
      if (r_tx_crd == '0) r_err_credit <= 1'b1;
      else                r_tx_crd     <= r_tx_crd - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             r_pend <= '0;
    else if (w_pop && !w_ack) r_pend <= r_pend + CW'(1);
    else if (w_ack && !w_pop) r_pend <= r_pend - CW'(1);
  end

  assign bus.rx_data       = w_empty ? '0 : w_rdata;
  assign bus.rx_data_valid = ~w_empty;
  assign bus.crd_ret_req   = (r_pend != '0);
  assign bus.tx_crd_avail  = r_tx_crd;
  assign bus.tx_can_send   = (r_tx_crd != '0);
  assign bus.alct_grant    = r_alct_p1;
  assign bus.err_overflow  = r_err_overflow;
  assign bus.err_credit    = r_err_credit;

`ifdef RDI_RX_STATS_EN
  logic [15:0] r_stat_data;
  logic [15:0] r_stat_crd;
  logic [15:0] r_stat_alct;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_data <= '0;
      r_stat_crd  <= '0;
      r_stat_alct <= '0;
    end else begin
      r_stat_data <= sat_inc16(r_stat_data, w_data_hit);
      r_stat_crd  <= sat_inc16(r_stat_crd,  w_crd_hit);
      r_stat_alct <= sat_inc16(r_stat_alct, w_alct_hit);
    end
  end

  assign bus.stat_data_cnt = r_stat_data;
  assign bus.stat_crd_cnt  = r_stat_crd;
  assign bus.stat_alct_cnt = r_stat_alct;
`endif

endmodule

// File: tb/tb_rdi_rx_datapath.sv
// Directed bench for rdi_rx_datapath: reset state, payload latency, overflow,
// combined flags, credit limits, credit return and mid-stream reset.
module tb_rdi_rx_datapath;
  import rdi_flit_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  rdi_rx_datapath_if #(.FLIT_W(512), .DATA_W(256), .CW(4)) bus ();

  rdi_rx_datapath #(
    .NBYTES(64), .DATA_W(256), .RX_DEPTH(8), .TX_CRD_INIT(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] mk(input logic [7:0] b, input logic [2:0] fl);
    logic [511:0] f;
    f = '0;
    f[511:256] = {32{b}};
    if (fl[0]) f = f | DATA_BIT_MASK;
    if (fl[1]) f = f | CRD_BIT_MASK;
    if (fl[2]) f = f | ALCT_BIT_MASK;
    return f;
  endfunction

  function automatic logic [255:0] pl(input logic [7:0] b);
    return {32{b}};
  endfunction

  task automatic send_flit(input logic [7:0] b, input logic [2:0] fl);
    bus.pl_data  = mk(b, fl);
    bus.pl_valid = 1'b1;
    tick();
    bus.pl_valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.enable        = 1'b1;
    bus.pl_valid      = 1'b0;
    bus.pl_data       = '0;
    bus.rx_data_ready = 1'b0;
    bus.crd_ret_ack   = 1'b0;
    bus.tx_cmd_sent   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // reset state
    chk("rst_valid",   256'(bus.rx_data_valid), 256'd0);
    chk("rst_data",    bus.rx_data, 256'd0);
    chk("rst_req",     256'(bus.crd_ret_req), 256'd0);
    chk("rst_avail",   256'(bus.tx_crd_avail), 256'd8);
    chk("rst_cansend", 256'(bus.tx_can_send), 256'd1);
    chk("rst_alct",    256'(bus.alct_grant), 256'd0);
    chk("rst_ovf",     256'(bus.err_overflow), 256'd0);
    chk("rst_crderr",  256'(bus.err_credit), 256'd0);

    // single data flit: visible after the second edge, pop raises a return request
    bus.rx_data_ready = 1'b1;
    send_flit(8'hA5, 3'b001);
    tick();
    chk("lat_e1_valid", 256'(bus.rx_data_valid), 256'd0);
    tick();
    chk("lat_e2_valid", 256'(bus.rx_data_valid), 256'd1);
    chk("lat_e2_data",  bus.rx_data, pl(8'hA5));
    tick();
    chk("pop_valid", 256'(bus.rx_data_valid), 256'd0);
    chk("pop_req",   256'(bus.crd_ret_req), 256'd1);
    bus.rx_data_ready = 1'b0;
    tick();
    chk("req_hold", 256'(bus.crd_ret_req), 256'd1);
    bus.crd_ret_ack = 1'b1;
    tick();
    bus.crd_ret_ack = 1'b0;
    chk("req_acked", 256'(bus.crd_ret_req), 256'd0);

    // nine back-to-back data flits into an 8-deep FIFO
    for (int i = 0; i < 9; i++) begin
      bus.pl_data  = mk(8'(8'h10 + i), 3'b001);
      bus.pl_valid = 1'b1;
      tick();
    end
    bus.pl_valid = 1'b0;
    chk("ovf_early", 256'(bus.err_overflow), 256'd0);
    tick();
    chk("ovf_8th", 256'(bus.err_overflow), 256'd0);
    tick();
    chk("ovf_9th", 256'(bus.err_overflow), 256'd1);
    bus.rx_data_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain_valid%0d", k), 256'(bus.rx_data_valid), 256'd1);
      chk($sformatf("drain_data%0d", k), bus.rx_data, pl(8'(8'h10 + k)));
      tick();
    end
    bus.rx_data_ready = 1'b0;
    chk("drain_empty", 256'(bus.rx_data_valid), 256'd0);
    chk("drain_req",   256'(bus.crd_ret_req), 256'd1);
    bus.crd_ret_ack = 1'b1;
    repeat (8) tick();
    bus.crd_ret_ack = 1'b0;
    chk("drain_req_clr", 256'(bus.crd_ret_req), 256'd0);

    // DATA|CRD|ALCT together with tx_cmd_sent in the decode cycle
    send_flit(8'hC3, 3'b111);
    bus.tx_cmd_sent = 1'b1;
    tick();
    bus.tx_cmd_sent = 1'b0;
    chk("multi_alct1",  256'(bus.alct_grant), 256'd1);
    chk("multi_avail",  256'(bus.tx_crd_avail), 256'd8);
    chk("multi_crderr", 256'(bus.err_credit), 256'd0);
    tick();
    chk("multi_alct0", 256'(bus.alct_grant), 256'd0);
    chk("multi_valid", 256'(bus.rx_data_valid), 256'd1);
    chk("multi_data",  bus.rx_data, pl(8'hC3));
    bus.rx_data_ready = 1'b1;
    tick();
    bus.rx_data_ready = 1'b0;
    bus.crd_ret_ack   = 1'b1;
    tick();
    bus.crd_ret_ack   = 1'b0;

    // drain all transmit credits, then underflow, then one credit back
    bus.tx_cmd_sent = 1'b1;
    repeat (8) tick();
    chk("crd_avail0",  256'(bus.tx_crd_avail), 256'd0);
    chk("crd_cansend", 256'(bus.tx_can_send), 256'd0);
    chk("crd_noerr",   256'(bus.err_credit), 256'd0);
    tick();
    bus.tx_cmd_sent = 1'b0;
    chk("crd_under_cnt", 256'(bus.tx_crd_avail), 256'd0);
    chk("crd_under_err", 256'(bus.err_credit), 256'd1);
    send_flit(8'h00, 3'b010);
    tick();
    chk("crd_ret_avail", 256'(bus.tx_crd_avail), 256'd1);
    chk("crd_ret_can",   256'(bus.tx_can_send), 256'd1);
    tick();
    chk("crd_nodata", 256'(bus.rx_data_valid), 256'd0);

    // three pops, held acks, request lasts exactly three ack cycles
    for (int i = 0; i < 3; i++) begin
      bus.pl_data  = mk(8'(8'h31 + i), 3'b001);
      bus.pl_valid = 1'b1;
      tick();
    end
    bus.pl_valid = 1'b0;
    repeat (2) tick();
    chk("ret_head", bus.rx_data, pl(8'h31));
    bus.rx_data_ready = 1'b1;
    repeat (3) tick();
    bus.rx_data_ready = 1'b0;
    chk("ret_empty", 256'(bus.rx_data_valid), 256'd0);
    bus.crd_ret_ack = 1'b1;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("ret_req%0d", j), 256'(bus.crd_ret_req), 256'd1);
      tick();
    end
    bus.crd_ret_ack = 1'b0;
    chk("ret_req_done", 256'(bus.crd_ret_req), 256'd0);

    // asynchronous reset in the middle of traffic
    for (int i = 0; i < 2; i++) begin
      bus.pl_data  = mk(8'(8'h41 + i), 3'b001);
      bus.pl_valid = 1'b1;
      tick();
    end
    bus.pl_valid = 1'b0;
    repeat (2) tick();
    bus.rx_data_ready = 1'b1;
    tick();
    bus.rx_data_ready = 1'b0;
    bus.pl_data  = mk(8'h44, 3'b111);
    bus.pl_valid = 1'b1;
    tick();
    bus.pl_valid = 1'b0;
    chk("pre_rst_valid", 256'(bus.rx_data_valid), 256'd1);
    chk("pre_rst_req",   256'(bus.crd_ret_req), 256'd1);
    chk("pre_rst_ovf",   256'(bus.err_overflow), 256'd1);
    chk("pre_rst_crd",   256'(bus.err_credit), 256'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 256'(bus.rx_data_valid), 256'd0);
    chk("arst_req",   256'(bus.crd_ret_req), 256'd0);
    chk("arst_ovf",   256'(bus.err_overflow), 256'd0);
    chk("arst_crd",   256'(bus.err_credit), 256'd0);
    chk("arst_avail", 256'(bus.tx_crd_avail), 256'd8);
    chk("arst_data",  bus.rx_data, 256'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_valid", 256'(bus.rx_data_valid), 256'd0);
    chk("post_rst_alct",  256'(bus.alct_grant), 256'd0);
    chk("post_rst_avail", 256'(bus.tx_crd_avail), 256'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
